// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: bundles the fetch-side bus signals of the RV32IC fetch aligner.
// Groups: instruction-memory request/response, PC redirect, Decompressor
// side-channel (iw_comp out, iw_decomp back), and the instruction issue handshake.
// master = fetch_aligner side; slave = memory / decompressor / consumer side.
interface fetch_aligner_if;
    // Instruction memory port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // Redirect from the core
    logic        redirect;
    logic [31:0] redirect_pc;
    // Decompressor loop
    logic [15:0] iw_comp;
    logic [31:0] iw_decomp;
    // Instruction issue handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_comp;
    logic        instr_illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output iw_comp,
        input  iw_decomp,
        output instr_valid, instr, instr_pc, instr_is_comp, instr_illegal,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  iw_comp,
        output iw_decomp,
        input  instr_valid, instr, instr_pc, instr_is_comp, instr_illegal,
        output instr_ready
    );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: RV32IC fetch sequencer with a three-halfword realignment buffer.
// Latency: rvalid in cycle N -> instr_valid in cycle N+1; at most one fetch outstanding.
// Backpressure: instr held stable while !instr_ready; no new fetch issues once cnt >= 2.
// Ports: clk_i, rst_i (sync, active-high), bus_io (fetch_aligner_if.master):
//   imem_req/addr/gnt/rvalid/rdata  word fetch port
//   redirect/redirect_pc            flush and restart fetch
//   iw_comp -> iw_decomp            head halfword through the external Decompressor
//   instr_valid/ready + instr, instr_pc, instr_is_comp, instr_illegal
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fetch_aligner_if.master  bus_io
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no fetch outstanding
        S_WAIT  = 2'd1,   // one fetch outstanding, its data will be kept
        S_FLUSH = 2'd2    // one fetch outstanding, its data will be dropped
    } state_e;

    state_e           state_q;
    logic [2:0][15:0] buf_q, buf_d, buf_s;
    logic [1:0]       cnt_q, cnt_d, cnt_s;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fetch_addr_q;
    logic             skip_lo_q;

    logic head_comp;
    logic head_vld;
    logic req;
    logic granted;
    logic consume;
    logic keep_data;

    // Head decode: a halfword with [1:0] != 2'b11 is a complete 16-bit
    // instruction; otherwise the head needs both buf[0] and buf[1].
    assign head_comp = (buf_q[0][1:0] != 2'b11);
    assign head_vld  = (cnt_q != 2'd0) && (head_comp || (cnt_q >= 2'd2));

    // Fetch only when the buffer can absorb a full word even if nothing is
    // consumed before the response returns.
    assign req       = (state_q == S_IDLE) && (cnt_q <= 2'd1);
    assign granted   = req && bus_io.imem_gnt;

    // Redirect cancels a same-cycle consume and discards same-cycle data.
    assign consume   = head_vld && bus_io.instr_ready && !bus_io.redirect;
    assign keep_data = (state_q == S_WAIT) && bus_io.imem_rvalid && !bus_io.redirect;

    // Buffer datapath: consume first, then append the returning word at the
    // post-consume fill level.
    always_comb begin
        buf_s = buf_q;
        cnt_s = cnt_q;
        pc_d  = pc_q;
        if (consume) begin
            if (head_comp) begin
                buf_s[0] = buf_q[1];
                buf_s[1] = buf_q[2];
                cnt_s    = cnt_q - 2'd1;
                pc_d     = pc_q + 32'd2;
            end else begin
                buf_s[0] = buf_q[2];
                cnt_s    = cnt_q - 2'd2;
                pc_d     = pc_q + 32'd4;
            end
        end

        buf_d = buf_s;
        cnt_d = cnt_s;
        if (keep_data) begin
            if (skip_lo_q) begin
                // Fetch target was the upper halfword: the lower one precedes pc.
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == cnt_s) buf_d[i] = bus_io.imem_rdata[31:16];
                end
                cnt_d = cnt_s + 2'd1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == cnt_s)                       buf_d[i] = bus_io.imem_rdata[15:0];
                    if (3'(i) == ({1'b0, cnt_s} + 3'd1))      buf_d[i] = bus_io.imem_rdata[31:16];
                end
                cnt_d = cnt_s + 2'd2;
            end
        end

        if (bus_io.redirect) begin
            cnt_d = 2'd0;
            pc_d  = bus_io.redirect_pc & ~32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= 2'd0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC & ~32'd3;
            skip_lo_q    <= RESET_PC[1];
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
            if (bus_io.redirect) begin
                fetch_addr_q <= bus_io.redirect_pc & ~32'd3;
                skip_lo_q    <= bus_io.redirect_pc[1];
                case (state_q)
                    // A grant of the old address this cycle leaves a stale
                    // response in flight.
                    S_IDLE:          state_q <= granted ? S_FLUSH : S_IDLE;
                    S_WAIT, S_FLUSH: state_q <= bus_io.imem_rvalid ? S_IDLE : S_FLUSH;
                    default:         state_q <= S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (granted) begin
                            state_q      <= S_WAIT;
                            fetch_addr_q <= fetch_addr_q + 32'd4;
                        end
                    end
                    S_WAIT: begin
                        if (bus_io.imem_rvalid) begin
                            state_q   <= S_IDLE;
                            skip_lo_q <= 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        if (bus_io.imem_rvalid) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Request is forced low during reset since reset is only sampled at the edge.
    assign bus_io.imem_req      = req && !rst_i;
    assign bus_io.imem_addr     = fetch_addr_q;
    assign bus_io.iw_comp       = buf_q[0];
    assign bus_io.instr_valid   = head_vld;
    assign bus_io.instr         = head_comp ? bus_io.iw_decomp : {buf_q[1], buf_q[0]};
    assign bus_io.instr_pc      = pc_q;
    assign bus_io.instr_is_comp = head_vld && head_comp;
    assign bus_io.instr_illegal = head_vld && head_comp && (bus_io.iw_decomp == 32'hFFFF_FFFF);

endmodule
